// File: rtl/tag_pattern_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tag_pattern_generator                                         |
// | Purpose  : Wishbone-configured synthetic rising/falling tag-pair stream  |
// |            source on an AXI-Stream style multi-lane tag interface.       |
// | Options  : TAG_GEN_STALL_STATS_EN adds a 64b stall counter at 0x38.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tag_pattern_generator #(
  parameter int WORD_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [WORD_WIDTH-1:0]   m_axis_tkeep,
  output logic [6*WORD_WIDTH-1:0] m_axis_channel,
  output logic [64*WORD_WIDTH-1:0] m_axis_tagtime,
  input  logic                    wb_cyc,
  input  logic                    wb_stb,
  input  logic                    wb_we,
  input  logic [7:0]              wb_adr,
  input  logic [31:0]             wb_dat_i,
  output logic [31:0]             wb_dat_o,
  output logic                    wb_ack
);

  localparam logic [31:0] C_LANES_MAX = 32'(WORD_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic        w_req, w_wr, w_accept;
  logic [31:0] w_rd_data;

  logic [4:0]  r_cfg_chan;
  logic [63:0] r_cfg_start, r_cfg_period, r_cfg_high;
  logic [31:0] r_cfg_count, r_cfg_lanes;
  logic        r_start_req, r_stop_req, r_error, r_stop_pend;
  logic [63:0] r_emitted;

  logic [4:0]  r_sh_chan;
  logic [63:0] r_sh_period, r_sh_high;
  logic [31:0] r_sh_lanes;
  logic        r_sh_fall, r_sh_inf;

  logic [63:0] r_next_t;
  logic        r_phase;
  logic [32:0] r_remaining;
  logic        r_last;

  logic                     w_go, w_load_beat, w_finish, w_err_set;
  logic [WORD_WIDTH-1:0]    w_beat_keep;
  logic [6*WORD_WIDTH-1:0]  w_beat_chan;
  logic [64*WORD_WIDTH-1:0] w_beat_time;
  logic [63:0]              w_t;
  logic                     w_ph;
  logic [32:0]              w_rem;
  logic [63:0]              w_keep_cnt;
  logic [63:0]              w_stall;

  logic w_unused;
  assign w_unused = &{1'b0, wb_adr[1:0]};

  assign w_req    = wb_cyc && wb_stb && !wb_ack;
  assign w_wr     = w_req && wb_we;
  assign w_accept = m_axis_tvalid && m_axis_tready;

  // Configuration registers and one-cycle command pulses from the control word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_chan   <= 5'd1;
      r_cfg_start  <= '0;
      r_cfg_period <= 64'h0068_0000;
      r_cfg_high   <= 64'h0034_0000;
      r_cfg_count  <= '0;
      r_cfg_lanes  <= C_LANES_MAX;
      r_start_req  <= 1'b0;
      r_stop_req   <= 1'b0;
    end else begin
      r_start_req <= 1'b0;
      r_stop_req  <= 1'b0;
      if (w_wr) begin
        case (wb_adr[7:2])
          6'h02: begin
            r_start_req <= wb_dat_i[0] && !wb_dat_i[1];
            r_stop_req  <= wb_dat_i[1];
          end
          6'h03: r_cfg_chan           <= wb_dat_i[4:0];
          6'h04: r_cfg_start[31:0]    <= wb_dat_i;
          6'h05: r_cfg_start[63:32]   <= wb_dat_i;
          6'h06: r_cfg_period[31:0]   <= wb_dat_i;
          6'h07: r_cfg_period[63:32]  <= wb_dat_i;
          6'h08: r_cfg_high[31:0]     <= wb_dat_i;
          6'h09: r_cfg_high[63:32]    <= wb_dat_i;
          6'h0A: r_cfg_count          <= wb_dat_i;
          6'h0B: r_cfg_lanes <= (wb_dat_i == 32'd0 || wb_dat_i > C_LANES_MAX) ? C_LANES_MAX : wb_dat_i;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (wb_adr[7:2])
      6'h00: w_rd_data = 32'd2;
      6'h02: w_rd_data = {30'd0, r_error, (r_state != S_IDLE)};
      6'h03: w_rd_data = {27'd0, r_cfg_chan};
      6'h04: w_rd_data = r_cfg_start[31:0];
      6'h05: w_rd_data = r_cfg_start[63:32];
      6'h06: w_rd_data = r_cfg_period[31:0];
      6'h07: w_rd_data = r_cfg_period[63:32];
      6'h08: w_rd_data = r_cfg_high[31:0];
      6'h09: w_rd_data = r_cfg_high[63:32];
      6'h0A: w_rd_data = r_cfg_count;
      6'h0B: w_rd_data = r_cfg_lanes;
      6'h0C: w_rd_data = r_emitted[31:0];
      6'h0D: w_rd_data = r_emitted[63:32];
      6'h0E: w_rd_data = w_stall[31:0];
      6'h0F: w_rd_data = w_stall[63:32];
      default: w_rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack   <= w_req;
      wb_dat_o <= (w_req && !wb_we) ? w_rd_data : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_go        = 1'b0;
    w_load_beat = 1'b0;
    w_finish    = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_start_req) begin
          if (r_cfg_period == 64'd0) begin
            w_err_set = 1'b1;
          end else begin
            w_go        = 1'b1;
            w_state_nxt = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (r_stop_req) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_load_beat = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          if (r_last || r_stop_pend || r_stop_req) begin
            w_finish    = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_load_beat = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Walk the tag sequence lane by lane to assemble the next beat
  always_comb begin
    w_t         = r_next_t;
    w_ph        = r_phase;
    w_rem       = r_remaining;
    w_beat_keep = '0;
    w_beat_chan = '0;
    w_beat_time = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if ((32'(i) < r_sh_lanes) && (r_sh_inf || (w_rem != 33'd0))) begin
        w_beat_keep[i]          = 1'b1;
        w_beat_chan[6*i +: 6]   = {w_ph, r_sh_chan};
        w_beat_time[64*i +: 64] = w_ph ? (w_t + r_sh_high) : w_t;
        if (!r_sh_inf) w_rem = w_rem - 33'd1;
        if (r_sh_fall && !w_ph) begin
          w_ph = 1'b1;
        end else begin
          w_ph = 1'b0;
          w_t  = w_t + r_sh_period;
        end
      end
    end
  end

  always_comb begin
    w_keep_cnt = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      w_keep_cnt = w_keep_cnt + {63'd0, m_axis_tkeep[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid  <= 1'b0;
      m_axis_tkeep   <= '0;
      m_axis_channel <= '0;
      m_axis_tagtime <= '0;
      r_error        <= 1'b0;
      r_stop_pend    <= 1'b0;
      r_emitted      <= '0;
      r_sh_chan      <= '0;
      r_sh_period    <= '0;
      r_sh_high      <= '0;
      r_sh_lanes     <= C_LANES_MAX;
      r_sh_fall      <= 1'b0;
      r_sh_inf       <= 1'b0;
      r_next_t       <= '0;
      r_phase        <= 1'b0;
      r_remaining    <= '0;
      r_last         <= 1'b0;
    end else begin
      if (w_err_set) r_error <= 1'b1;
      if (w_accept)  r_emitted <= r_emitted + w_keep_cnt;
      if (r_stop_req && r_state == S_RUN) r_stop_pend <= 1'b1;
      if (w_go) begin
        r_error     <= 1'b0;
        r_emitted   <= '0;
        r_stop_pend <= 1'b0;
        r_sh_chan   <= r_cfg_chan;
        r_sh_period <= r_cfg_period;
        r_sh_high   <= r_cfg_high;
        r_sh_lanes  <= r_cfg_lanes;
        r_sh_fall   <= (r_cfg_high != 64'd0) && (r_cfg_high < r_cfg_period);
        r_sh_inf    <= (r_cfg_count == 32'd0);
        r_remaining <= ((r_cfg_high != 64'd0) && (r_cfg_high < r_cfg_period)) ?
                       {r_cfg_count, 1'b0} : {1'b0, r_cfg_count};
        r_next_t    <= r_cfg_start;
        r_phase     <= 1'b0;
      end
      if (w_load_beat) begin
        m_axis_tvalid  <= 1'b1;
        m_axis_tkeep   <= w_beat_keep;
        m_axis_channel <= w_beat_chan;
        m_axis_tagtime <= w_beat_time;
        r_next_t       <= w_t;
        r_phase        <= w_ph;
        r_remaining    <= w_rem;
        r_last         <= !r_sh_inf && (w_rem == 33'd0);
      end else if (w_finish) begin
        m_axis_tvalid  <= 1'b0;
        m_axis_tkeep   <= '0;
        m_axis_channel <= '0;
        m_axis_tagtime <= '0;
        r_stop_pend    <= 1'b0;
      end
    end
  end

`ifdef TAG_GEN_STALL_STATS_EN
  logic [63:0] r_stall;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (w_go) begin
      r_stall <= '0;
    end else if (m_axis_tvalid && !m_axis_tready && (r_stall != '1)) begin
      r_stall <= r_stall + 64'd1;
    end
  end
  assign w_stall = r_stall;
`else
  assign w_stall = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tag_pattern_generator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_tag_pattern_generator                                      |
// | Purpose  : Directed bench with a tag-list reference model and per-cycle  |
// |            beat comparison for tag_pattern_generator.                    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_tag_pattern_generator;

  localparam int WW = 4;
  localparam int BW = WW + 6*WW + 64*WW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_axis_tvalid, m_axis_tready;
  logic [WW-1:0] m_axis_tkeep;
  logic [6*WW-1:0] m_axis_channel;
  logic [64*WW-1:0] m_axis_tagtime;
  logic wb_cyc, wb_stb, wb_we, wb_ack;
  logic [7:0] wb_adr;
  logic [31:0] wb_dat_i, wb_dat_o;

  tag_pattern_generator #(.WORD_WIDTH(WW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_channel(m_axis_channel),
    .m_axis_tagtime(m_axis_tagtime),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc_n = 0;
  int ack_cyc = 0;
  int first_tv_cyc = -1;
  bit chk_en = 1'b0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] first_beat, last_beat;
  logic [31:0] rd;

  always @(posedge clk) cyc_n = cyc_n + 1;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Every cycle with tvalid, the beat on the bus must equal the head of the model queue
  always @(negedge clk) begin
    logic [BW-1:0] act;
    #1;
    act = {m_axis_tkeep, m_axis_channel, m_axis_tagtime};
    if (chk_en && rst_n && m_axis_tvalid) begin
      if (first_tv_cyc < 0) begin
        first_tv_cyc = cyc_n;
        first_beat   = act;
      end
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL extra_beat: got %0h expected no beat", act);
      end else begin
        chk("beat", act, exp_q[0]);
        if (m_axis_tready) begin
          last_beat = act;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Reference: list every tag of the run by closed-form time, then cut into beats
  task automatic model(input logic [63:0] st, input logic [63:0] per, input logic [63:0] hi,
                       input int unsigned cnt, input int unsigned lanes_w,
                       input logic [4:0] ch, input int inf_pairs);
    logic [63:0] tt[$];
    logic fl[$];
    logic [BW-1:0] b;
    int ln, np;
    bit fall;
    ln   = (lanes_w == 0 || lanes_w > WW) ? WW : int'(lanes_w);
    fall = (hi != 0) && (hi < per);
    np   = (cnt == 0) ? inf_pairs : int'(cnt);
    for (int p = 0; p < np; p++) begin
      logic [63:0] base;
      base = st + per * 64'(p);
      tt.push_back(base); fl.push_back(1'b0);
      if (fall) begin tt.push_back(base + hi); fl.push_back(1'b1); end
    end
    exp_q.delete();
    for (int k = 0; k < tt.size(); k += ln) begin
      b = '0;
      for (int j = 0; j < ln && k + j < tt.size(); j++) begin
        b[280 + j]       = 1'b1;
        b[256 + 6*j +: 6] = {fl[k+j], ch};
        b[64*j +: 64]    = tt[k+j];
      end
      exp_q.push_back(b);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [7:0] adr, input logic [31:0] d,
                         output logic [31:0] q);
    int n;
    n = 0;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = d;
    do begin
      @(posedge clk); #1; n++;
    end while (!wb_ack && n < 10);
    chk("wb_ack_latency", BW'(n), BW'(1));
    q = wb_dat_o;
    ack_cyc = cyc_n;
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wr(input logic [7:0] adr, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(1'b1, adr, d, q);
  endtask

  task automatic wr64(input logic [7:0] adr, input logic [63:0] d);
    wr(adr, d[31:0]);
    wr(adr + 8'd4, d[63:32]);
  endtask

  task automatic rdchk(input string nm, input logic [7:0] adr, input logic [31:0] exp);
    logic [31:0] q;
    wb_xfer(1'b0, adr, 32'd0, q);
    chk(nm, BW'(q), BW'(exp));
  endtask

  task automatic configure(input logic [63:0] st, input logic [63:0] per, input logic [63:0] hi,
                           input int unsigned cnt, input int unsigned lanes_w, input logic [4:0] ch);
    wr64(8'h10, st); wr64(8'h18, per); wr64(8'h20, hi);
    wr(8'h28, cnt); wr(8'h2C, lanes_w); wr(8'h0C, {27'd0, ch});
  endtask

  task automatic start_run();
    first_tv_cyc = -1;
    chk_en = 1'b1;
    wr(8'h08, 32'd1);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while ((m_axis_tvalid || exp_q.size() != 0) && n < 300);
    chk(nm, BW'(exp_q.size()), BW'(0));
    repeat (3) @(negedge clk);
    chk({nm, "_idle_tvalid"}, BW'(m_axis_tvalid), BW'(0));
  endtask

  task automatic wait_tvalid(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!m_axis_tvalid && n < 50);
    chk(nm, BW'(m_axis_tvalid), BW'(1));
  endtask

  localparam logic [5:0] R5 = {1'b0, 5'd5};
  localparam logic [5:0] F5 = {1'b1, 5'd5};

  initial begin
    m_axis_tready = 1'b1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0; wb_dat_i = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tvalid", BW'(m_axis_tvalid), BW'(0));
    chk("rst_tkeep", BW'(m_axis_tkeep), BW'(0));
    chk("rst_ack", BW'(wb_ack), BW'(0));
    chk("rst_dat_o", BW'(wb_dat_o), BW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    rdchk("presence", 8'h00, 32'd2);
    rdchk("rst_period", 8'h18, 32'h0068_0000);
    rdchk("rst_high", 8'h20, 32'h0034_0000);
    rdchk("rst_channel", 8'h0C, 32'd1);
    rdchk("rst_lanes", 8'h2C, WW);
    rdchk("rst_control", 8'h08, 32'd0);
    wr(8'h2C, 32'd9);
    rdchk("lanes_clamp", 8'h2C, WW);

    // Basic run: three pairs over two beats
    configure(64'd1000, 64'd100, 64'd40, 3, 4, 5'd5);
    model(64'd1000, 64'd100, 64'd40, 3, 4, 5'd5, 0);
    start_run();
    wait_done("runA_done");
    chk("runA_latency", BW'(first_tv_cyc), BW'(ack_cyc + 2));
    chk("runA_beat0", first_beat, {4'b1111, F5, R5, F5, R5, 64'd1140, 64'd1100, 64'd1040, 64'd1000});
    chk("runA_beat1", last_beat, {4'b0011, 12'd0, F5, R5, 64'd0, 64'd0, 64'd1240, 64'd1200});
    rdchk("runA_emitted", 8'h30, 32'd6);
    rdchk("runA_emitted_hi", 8'h34, 32'd0);
    rdchk("runA_control", 8'h08, 32'd0);

    // Same run with five stall cycles on the first beat
    m_axis_tready = 1'b0;
    model(64'd1000, 64'd100, 64'd40, 3, 4, 5'd5, 0);
    start_run();
    wait_tvalid("runB_tvalid");
    repeat (5) @(posedge clk);
    #1;
    chk("runB_hold", BW'(m_axis_tagtime), BW'({64'd1140, 64'd1100, 64'd1040, 64'd1000}));
    @(negedge clk);
    m_axis_tready = 1'b1;
    wait_done("runB_done");
`ifdef TAG_GEN_STALL_STATS_EN
    rdchk("runB_stall", 8'h38, 32'd5);
`else
    rdchk("runB_stall", 8'h38, 32'd0);
`endif
    rdchk("runB_stall_hi", 8'h3C, 32'd0);

    // Rising-only tags, three lanes
    configure(64'd0, 64'd10, 64'd0, 4, 3, 5'd2);
    model(64'd0, 64'd10, 64'd0, 4, 3, 5'd2, 0);
    start_run();
    wait_done("runC_done");
    chk("runC_beat0", first_beat, {4'b0111, 6'd0, 6'd2, 6'd2, 6'd2, 64'd0, 64'd20, 64'd10, 64'd0});
    chk("runC_beat1", last_beat, {4'b0001, 18'd0, 6'd2, 192'd0, 64'd30});
    rdchk("runC_emitted", 8'h30, 32'd4);

    // Zero period must refuse to start
    wr64(8'h18, 64'd0);
    exp_q.delete();
    start_run();
    repeat (10) @(negedge clk);
    rdchk("err_control", 8'h08, 32'd2);

    // Infinite run stopped while the first beat is stalled
    configure(64'd7, 64'd5, 64'd2, 0, 2, 5'd3);
    model(64'd7, 64'd5, 64'd2, 0, 2, 5'd3, 20);
    m_axis_tready = 1'b0;
    start_run();
    wait_tvalid("runD_tvalid");
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    wr(8'h08, 32'd2);
    @(negedge clk);
    m_axis_tready = 1'b1;
    wait_done("runD_done");
    chk("runD_beat", last_beat, {4'b0011, 12'd0, {1'b1, 5'd3}, {1'b0, 5'd3}, 128'd0, 64'd9, 64'd7});
    rdchk("runD_emitted", 8'h30, 32'd2);
    rdchk("runD_control", 8'h08, 32'd0);

    // 64-bit wrap of tag times
    configure(64'hFFFF_FFFF_FFFF_FFCE, 64'd100, 64'd10, 2, 4, 5'd5);
    model(64'hFFFF_FFFF_FFFF_FFCE, 64'd100, 64'd10, 2, 4, 5'd5, 0);
    start_run();
    wait_done("runE_done");
    chk("runE_beat", last_beat, {4'b1111, F5, R5, F5, R5, 64'd60, 64'd50,
                                 64'hFFFF_FFFF_FFFF_FFD8, 64'hFFFF_FFFF_FFFF_FFCE});

    // Asynchronous reset in the middle of a stalled beat
    configure(64'd0, 64'd5, 64'd1, 0, 4, 5'd1);
    model(64'd0, 64'd5, 64'd1, 0, 4, 5'd1, 10);
    m_axis_tready = 1'b0;
    start_run();
    wait_tvalid("runF_tvalid");
    chk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tvalid", BW'(m_axis_tvalid), BW'(0));
    chk("async_rst_tkeep", BW'(m_axis_tkeep), BW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    rdchk("post_rst_presence", 8'h00, 32'd2);
    rdchk("post_rst_period", 8'h18, 32'h0068_0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
